// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand/result width; must be a multiple of 4.
  localparam int DEFAULT_WIDTH = 16;

  // Iteration counter width for the default width.
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

endpackage : divider_pkg

// File: rtl/cla_subtractor.sv
// Lookahead subtractor: diff = a - b computed as a + ~b + 1.
// Bits are organised in 4-bit propagate/generate groups; carries into each
// group come from a group-level lookahead chain, and carries inside a group
// are expanded from that group's carry-in. The last group may be partial.
module cla_subtractor #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [NG-2:0]    gp;
  logic [NG-2:0]    gg;
  logic [NG-1:0]    gc;
  logic [WIDTH:0]   cb;

  assign nb = ~b;
  assign p  = a ^ nb;
  assign g  = a & nb;

  // Group P/G, group carry lookahead, then per-bit carries from group carry-in.
  always_comb begin
    logic c;
    int   base;
    int   grp;
    gp = '0;
    gg = '0;
    gc = '0;
    cb = '0;
    c  = 1'b0;
    for (int gi = 0; gi < NG - 1; gi++) begin
      base   = gi * 4;
      gp[gi] = p[base] & p[base+1] & p[base+2] & p[base+3];
      gg[gi] = g[base+3]
             | (p[base+3] & g[base+2])
             | (p[base+3] & p[base+2] & g[base+1])
             | (p[base+3] & p[base+2] & p[base+1] & g[base]);
    end
    gc[0] = 1'b1;
    for (int gi = 1; gi < NG; gi++) begin
      gc[gi] = gg[gi-1] | (gp[gi-1] & gc[gi-1]);
    end
    for (int i = 0; i <= WIDTH; i++) begin
      grp  = ((i / 4) < NG) ? (i / 4) : (NG - 1);
      base = grp * 4;
      c    = gc[grp];
      for (int k = base; k < i; k++) begin
        c = g[k] | (p[k] & c);
      end
      cb[i] = c;
    end
  end

  assign diff      = p ^ cb[WIDTH-1:0];
  assign no_borrow = cb[WIDTH];

endmodule : cla_subtractor

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift-subtract step per clock,
// quotient/remainder registered on entry to DONE with a one-cycle done pulse.
// A zero divisor spends a single RUN cycle being recognised, then reports
// all-ones quotient, remainder = dividend and div_by_zero.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             zero_div;
  logic             unused_r_msb;

  // After every step R is below the divisor, so its MSB is always zero and
  // the left shift can drop it; the extra bit lives only in the trial value.
  assign unused_r_msb = r[WIDTH];

  assign r_shift  = {r[WIDTH-1:0], q[WIDTH-1]};
  assign zero_div = (divisor_reg == '0);

  cla_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a        (r_shift),
    .b        ({1'b0, divisor_reg}),
    .diff     (diff),
    .no_borrow(no_borrow)
  );

  assign r_next = no_borrow ? diff : r_shift;
  assign q_next = {q[WIDTH-2:0], no_borrow};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (zero_div || (count == LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, shift-subtract iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      r            <= '0;
      q            <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            r            <= '0;
            q            <= dividend;
            count        <= '0;
          end
        end
        RUN: begin
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= dividend_reg;
            div_by_zero <= 1'b1;
          end else begin
            r     <= r_next;
            q     <= q_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              quotient    <= q_next;
              remainder   <= r_next[WIDTH-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with hand-computed expected results.
module tb_restoring_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int total;
  int bad;

  restoring_divider #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with both values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a one-cycle start; returns at the falling edge after the capture edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles since the start strobe.
  task automatic waitDone(input int fromCyc, output int cyc);
    cyc = fromCyc;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Full divide with result, latency and pulse-width checks.
  task automatic runDivide(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input int expLat,
                           input logic [15:0] expQ, input logic [15:0] expR,
                           input logic expDz);
    int lat;
    applyStimulus(a, b);
    checkOutput({tag, "_busy_run"}, 32'(busy), 32'd1);
    waitDone(1, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_quot"}, 32'(quotient), 32'(expQ));
    checkOutput({tag, "_rem"}, 32'(remainder), 32'(expR));
    checkOutput({tag, "_dz"}, 32'(div_by_zero), 32'(expDz));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_quot_held"}, 32'(quotient), 32'(expQ));
  endtask

  initial begin
    int lat;
    int sawDone;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #12;
    checkOutput("rst_quot", 32'(quotient), 32'd0);
    checkOutput("rst_rem", 32'(remainder), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runDivide("d100_7", 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0);
    runDivide("dffff_1", 16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0);
    runDivide("dffff_ffff", 16'hFFFF, 16'hFFFF, 17, 16'd1, 16'd0, 1'b0);
    runDivide("d3_10", 16'd3, 16'd10, 17, 16'd0, 16'd3, 1'b0);
    runDivide("d0_5", 16'd0, 16'd5, 17, 16'd0, 16'd0, 1'b0);
    runDivide("d5_0", 16'd5, 16'd0, 2, 16'hFFFF, 16'd5, 1'b1);
    runDivide("d9_4", 16'd9, 16'd4, 17, 16'd2, 16'd1, 1'b0);

    // Start during RUN cycle 6 must not disturb the divide in flight.
    applyStimulus(16'd100, 16'd7);
    repeat (5) @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitDone(7, lat);
    checkOutput("ignore_latency", 32'(lat), 32'd17);
    checkOutput("ignore_quot", 32'(quotient), 32'd14);
    checkOutput("ignore_rem", 32'(remainder), 32'd2);

    // Back-to-back start in the cycle right after done.
    runDivide("b2b_50_5", 16'd50, 16'd5, 17, 16'd10, 16'd0, 1'b0);

    // Asynchronous reset in RUN cycle 8 aborts the divide.
    applyStimulus(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_quot", 32'(quotient), 32'd0);
    checkOutput("abort_rem", 32'(remainder), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_dz", 32'(div_by_zero), 32'd0);
    sawDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) sawDone++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) sawDone++;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);

    runDivide("d1000_3", 16'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_restoring_divider
